// File: rtl/hit_judge.sv
// Reaction game judge: synchronizes and debounces 8 buttons, lights a pseudo-random
// target and scores correct presses, flagging wrong presses and timeouts as misses.
module hit_judge #(
    parameter int          DEBOUNCE_CYC = 50000,
    parameter int          WINDOW_CYC   = 25000000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  btn,
    input  logic        game_over,
    output logic [7:0]  target,
    output logic        hit,
    output logic        miss,
    output logic [13:0] score,
    output logic        playing
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int WIN_W = $clog2(WINDOW_CYC + 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW_CYC - 1);
    localparam logic [13:0]      SCORE_MAX = 14'd9999;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_RELEASE,
        S_DONE
    } state_t;

    function automatic logic [13:0] sat_inc(input logic [13:0] value);
        if (value >= SCORE_MAX) return SCORE_MAX;
        return value + 14'd1;
    endfunction

    logic [7:0]      sync_p0, sync_p1;
    logic [7:0]      db_level, db_prev, press;
    logic [DB_W-1:0] db_cnt [8];
    logic [15:0]     lfsr;
    logic [2:0]      prev_idx, prev_idx_n, idx_raw, idx_sel;
    logic [WIN_W-1:0] win_cnt, win_cnt_n;
    state_t          state, state_n;
    logic [7:0]      target_n;
    logic            hit_n, miss_n, playing_n;
    logic [13:0]     score_n;

    // Stage p0/p1: two-flop synchronizer, then per-button debounce counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            db_level <= '0;
            db_prev  <= '0;
            for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            db_prev <= db_level;
            for (int i = 0; i < 8; i++) begin
                if (sync_p1[i] != db_level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_level[i] <= sync_p1[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press = db_level & ~db_prev;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    // Never repeat the previous target: bump the index by one (mod 8) on a collision
    assign idx_raw = lfsr[2:0];
    assign idx_sel = (idx_raw == prev_idx) ? idx_raw + 3'd1 : idx_raw;

    always_comb begin
        state_n    = state;
        target_n   = target;
        hit_n      = 1'b0;
        miss_n     = 1'b0;
        score_n    = score;
        prev_idx_n = prev_idx;
        win_cnt_n  = win_cnt;
        case (state)
            S_IDLE: begin
                target_n = '0;
                if (start) state_n = S_ARM;
            end
            S_ARM: begin
                prev_idx_n = idx_sel;
                target_n   = 8'b1 << idx_sel;
                win_cnt_n  = '0;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                win_cnt_n = win_cnt + 1'b1;
                if (press != '0) begin
                    if ((press & ~target) != '0) begin
                        miss_n = 1'b1;
                    end else begin
                        hit_n   = 1'b1;
                        score_n = sat_inc(score);
                    end
                    target_n = '0;
                    state_n  = S_RELEASE;
                end else if (win_cnt == WIN_LAST) begin
                    miss_n   = 1'b1;
                    target_n = '0;
                    state_n  = S_RELEASE;
                end
            end
            S_RELEASE: begin
                target_n = '0;
                if (db_level == '0) state_n = S_ARM;
            end
            default: begin
                target_n = '0;
            end
        endcase
        // game_over overrides everything, including a judgement due this cycle
        if (game_over && state != S_DONE) begin
            state_n  = S_DONE;
            target_n = '0;
            hit_n    = 1'b0;
            miss_n   = 1'b0;
            score_n  = score;
        end
        playing_n = (state_n == S_ARM) || (state_n == S_WAIT) || (state_n == S_RELEASE);
    end

    // Stage p2: registered FSM state and outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            target   <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            score    <= '0;
            playing  <= 1'b0;
            prev_idx <= '0;
            win_cnt  <= '0;
        end else begin
            state    <= state_n;
            target   <= target_n;
            hit      <= hit_n;
            miss     <= miss_n;
            score    <= score_n;
            playing  <= playing_n;
            prev_idx <= prev_idx_n;
            win_cnt  <= win_cnt_n;
        end
    end

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: a behavioural game model predicts pulses and lit
// targets; a monitor pops and compares them whenever the DUT shows one.
module tb_hit_judge;

    localparam int DEB = 4;
    localparam int WIN = 20;

    logic        clock = 1'b0;
    logic        reset, start, game_over;
    logic [7:0]  btn;
    logic [7:0]  target;
    logic        hit, miss, playing;
    logic [13:0] score;

    hit_judge #(.DEBOUNCE_CYC(DEB), .WINDOW_CYC(WIN), .LFSR_SEED(16'hACE1)) dut (
        .clock(clock), .reset(reset), .start(start), .btn(btn), .game_over(game_over),
        .target(target), .hit(hit), .miss(miss), .score(score), .playing(playing)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { bit is_hit; int sc; int cyc; } pulse_t;
    typedef struct { logic [7:0] tgt; int cyc; } lit_t;
    pulse_t pq[$];
    lit_t   lq[$];

    task automatic check(input string nm, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Behavioural model: phases 0 idle, 1 arm, 2 wait, 3 release, 4 done
    int         m_ph, m_score, m_prev_idx, m_arm_cyc, m_lfsr;
    logic [7:0] m_tgt, m_raw_d1, m_raw_d2, m_lvl, m_lvl_d;
    logic [7:0] m_hist [DEB];

    task automatic model_reset();
        m_ph = 0; m_score = 0; m_prev_idx = 0; m_arm_cyc = 0; m_lfsr = 'hACE1;
        m_tgt = 0; m_raw_d1 = 0; m_raw_d2 = 0; m_lvl = 0; m_lvl_d = 0;
        for (int k = 0; k < DEB; k++) m_hist[k] = 0;
        pq.delete();
        lq.delete();
    endtask

    // Advance the model over the clock edge that will sample the inputs now applied
    task automatic model_step(input int t);
        logic [7:0] prs, nl, old_tgt;
        int idx, fb;
        bit nh, nm;
        prs = m_lvl & ~m_lvl_d;
        nh = 0; nm = 0; old_tgt = m_tgt;
        if (m_ph != 4 && game_over) begin
            m_ph = 4; m_tgt = 0;
        end else begin
            case (m_ph)
                0: if (start) m_ph = 1;
                1: begin
                    idx = m_lfsr % 8;
                    if (idx == m_prev_idx) idx = (idx + 1) % 8;
                    m_prev_idx = idx;
                    m_tgt = 8'(1 << idx);
                    m_arm_cyc = t;
                    m_ph = 2;
                end
                2: begin
                    if (prs != 0) begin
                        if ((prs & ~m_tgt) != 0) nm = 1;
                        else begin
                            nh = 1;
                            if (m_score < 9999) m_score++;
                        end
                        m_tgt = 0; m_ph = 3;
                    end else if (t - m_arm_cyc == WIN) begin
                        nm = 1; m_tgt = 0; m_ph = 3;
                    end
                end
                3: if (m_lvl == 0) m_ph = 1;
                default: ;
            endcase
        end
        // a level flips once the last DEB synchronized samples all disagree with it
        for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_raw_d2;
        nl = m_lvl;
        for (int b = 0; b < 8; b++) begin
            bit all_diff;
            all_diff = 1;
            for (int k = 0; k < DEB; k++) if (m_hist[k][b] == m_lvl[b]) all_diff = 0;
            if (all_diff) nl[b] = ~m_lvl[b];
        end
        m_lvl_d = m_lvl;
        m_lvl = nl;
        m_raw_d2 = m_raw_d1;
        m_raw_d1 = btn;
        fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
        if (nh || nm) pq.push_back('{nh, m_score, t + 1});
        if (old_tgt == 0 && m_tgt != 0) lq.push_back('{m_tgt, t + 1});
    endtask

    task automatic tick(input logic st, input logic [7:0] b, input logic go);
        @(negedge clock);
        start = st; btn = b; game_over = go;
        model_step(cyc);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0; start = 1'b0; btn = '0; game_over = 1'b0;
        model_step(cyc);
    endtask

    task automatic wait_lit(input logic st);
        int n;
        n = 0;
        while (target == 0 && n < 80) begin
            tick(st, 8'h00, 1'b0);
            n++;
        end
        check("target_lit_in_time", target != 0, target, 1);
    endtask

    task automatic hold(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, b, 1'b0);
    endtask

    // Monitor: compares every DUT pulse and every newly lit target against the queues
    initial begin
        logic [7:0] prev_t;
        bit prev_p;
        pulse_t e;
        lit_t l;
        prev_t = 0; prev_p = 0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                prev_t = 0; prev_p = 0;
            end else begin
                if (hit || miss) begin
                    check("hit_miss_exclusive", !(hit && miss), {hit, miss}, 0);
                    check("no_back_to_back_pulse", !prev_p, 1, 0);
                    check("pulse_expected", pq.size() > 0, hit ? 1 : 2, 0);
                    if (pq.size() > 0) begin
                        e = pq.pop_front();
                        check("pulse_kind_hit", hit == e.is_hit, hit, e.is_hit);
                        check("pulse_score", score == e.sc, score, e.sc);
                        check("pulse_cycle", cyc == e.cyc, cyc, e.cyc);
                    end
                end
                if (target != 0 && prev_t == 0) begin
                    check("lit_expected", lq.size() > 0, target, 0);
                    if (lq.size() > 0) begin
                        l = lq.pop_front();
                        check("lit_target", target == l.tgt, target, l.tgt);
                        check("lit_cycle", cyc == l.cyc, cyc, l.cyc);
                    end
                end
                prev_t = target;
                prev_p = hit || miss;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t0, t1, other, pat;
        logic go;
        bit fired;
        int hold_n, r;
        reset = 1'b1; start = 1'b0; btn = '0; game_over = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_target", target == 0, target, 0);
        check("reset_hit_miss", !hit && !miss, {hit, miss}, 0);
        check("reset_score", score == 0, score, 0);
        check("reset_playing", playing == 0, playing, 0);
        release_reset();

        // correct press, then a new, different target
        tick(1'b1, 8'h00, 1'b0);
        wait_lit(1'b0);
        t0 = target;
        check("playing_in_wait", playing == 1, playing, 1);
        hold(t0, 10);
        check("hit_score_one", score == 1, score, 1);
        check("hit_target_cleared", target == 0, target, 0);
        wait_lit(1'b0);
        t1 = target;
        check("new_target_differs", t1 != t0, t1, t0);
        check("new_target_onehot", $countones(t1) == 1, $countones(t1), 1);

        // wrong press: miss, stay in release while held
        other = {t1[6:0], t1[7]};
        hold(other, 10);
        check("miss_score_kept", score == 1, score, 1);
        check("miss_target_cleared", target == 0, target, 0);
        hold(other, 8);
        check("release_while_held", target == 0 && playing == 1, target, 0);

        // timeout, then glitch, then simultaneous target and non-target
        wait_lit(1'b0);
        hold(8'h00, 25);
        wait_lit(1'b0);
        t0 = target;
        hold(t0, 3);
        hold(8'h00, 8);
        check("glitch_no_effect", target == t0 && score == 1, target, t0);
        hold(t0 | {t0[6:0], t0[7]}, 10);
        check("both_pressed_no_score", score == 1, score, 1);

        // randomized play
        for (int seg = 0; seg < 500; seg++) begin
            r = $urandom_range(0, 9);
            if (r < 4) pat = 8'h00;
            else if (r < 7) pat = target;
            else pat = 8'($urandom);
            hold_n = $urandom_range(1, 10);
            for (int i = 0; i < hold_n; i++) tick($urandom_range(0, 3) == 0, pat, 1'b0);
        end

        // asynchronous reset mid-WAIT
        hold(8'h00, 12);
        wait_lit(1'b1);
        hold(8'h00, 3);
        @(negedge clock);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset_target", target == 0, target, 0);
        check("async_reset_playing", playing == 0, playing, 0);
        repeat (3) @(negedge clock);
        release_reset();
        hold(8'h00, 10);
        check("post_reset_score", score == 0, score, 0);
        check("post_reset_idle", playing == 0 && target == 0, playing, 0);

        // score saturation via a forced preload
        tick(1'b1, 8'h00, 1'b0);
        wait_lit(1'b0);
        force dut.score = 14'd9998;
        m_score = 9998;
        tick(1'b0, 8'h00, 1'b0);
        release dut.score;
        hold(target, 10);
        check("score_reaches_max", score == 9999, score, 9999);
        wait_lit(1'b0);
        hold(target, 10);
        check("score_saturates", score == 9999, score, 9999);

        // game_over in the cycle of a target press event
        wait_lit(1'b0);
        t0 = target;
        fired = 0;
        for (int i = 0; i < 15; i++) begin
            go = fired || ((m_lvl & ~m_lvl_d) != 0);
            if (go) fired = 1;
            tick(1'b0, t0, go);
        end
        check("done_target", target == 0, target, 0);
        check("done_playing", playing == 0, playing, 0);
        check("done_score_held", score == 9999, score, 9999);
        for (int i = 0; i < 30; i++) tick(1'b1, 8'($urandom), 1'b0);
        check("done_ignores_start", playing == 0 && target == 0, playing, 0);
        check("done_score_still", score == 9999, score, 9999);

        hold(8'h00, 2);
        @(posedge clock);
        #2;
        check("pulse_queue_drained", pq.size() == 0, pq.size(), 0);
        check("lit_queue_drained", lq.size() == 0, lq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
